// File: rtl/tank_pkg.sv
// tank_pkg: shared button encodings, facing icons and FSM states for the tank blocks.
package tank_pkg;

    localparam logic [4:0] BTN_DOWN  = 5'b00001;
    localparam logic [4:0] BTN_RIGHT = 5'b00010;
    localparam logic [4:0] BTN_UP    = 5'b00100;
    localparam logic [4:0] BTN_LEFT  = 5'b01000;
    localparam logic [4:0] BTN_FIRE  = 5'b10000;

    localparam logic [1:0] ICON_UP    = 2'b00;
    localparam logic [1:0] ICON_DOWN  = 2'b01;
    localparam logic [1:0] ICON_LEFT  = 2'b10;
    localparam logic [1:0] ICON_RIGHT = 2'b11;

    typedef enum logic [1:0] {RUN, BOUNCE, RESPAWN} state_t;

    function automatic logic onehot_dir_valid(input logic [3:0] d);
        return $onehot(d);
    endfunction

    // Only meaningful when onehot_dir_valid(d) holds.
    function automatic logic [1:0] btn_to_icon(input logic [3:0] d);
        return (d == BTN_DOWN[3:0])  ? ICON_DOWN  :
               (d == BTN_RIGHT[3:0]) ? ICON_RIGHT :
               (d == BTN_LEFT[3:0])  ? ICON_LEFT  :
               (d == BTN_UP[3:0])    ? ICON_UP    : ICON_UP;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running 0..TICK_CNT counter emitting a one-cycle tick at the terminal count.
module tick_gen #(
    parameter int TICK_CNT = 500000
) (
    input  logic clk25,
    input  logic reset_n,
    output logic tick
);
    localparam int CW = $clog2(TICK_CNT + 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_CNT));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tank_motion_ctrl.sv
// tank_motion_ctrl: turns one-hot player buttons into a clamped tank position, facing,
// fire pulses, wall bounce-back and an explosion/respawn handshake.
module tank_motion_ctrl
    import tank_pkg::*;
#(
    parameter int XW            = 10,
    parameter int YW            = 9,
    parameter int TICK_CNT      = 500000,
    parameter int STEP          = 1,
    parameter int TANK_SIZE     = 32,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 479,
    parameter int RESPAWN_HOLD  = 64,
    parameter int FIRE_COOLDOWN = 32
) (
    input  logic          clk25,
    input  logic          reset_n,
    input  logic [XW-1:0] spawn_x,
    input  logic [YW-1:0] spawn_y,
    input  logic [4:0]    player,
    input  logic          wall_hit,
    input  logic          explosion_flag,
    output logic          red_explosion_ack,
    output logic [XW-1:0] x_tank,
    output logic [YW-1:0] y_tank,
    output logic [1:0]    direction,
    output logic          moving,
    output logic          fire
);
    localparam int HW = $clog2(RESPAWN_HOLD + 2);
    localparam int FW = $clog2(FIRE_COOLDOWN + 2);
    localparam logic [XW:0] X_LO = (XW+1)'(X_MIN);
    localparam logic [XW:0] X_HI = (XW+1)'(X_MAX - TANK_SIZE + 1);
    localparam logic [YW:0] Y_LO = (YW+1)'(Y_MIN);
    localparam logic [YW:0] Y_HI = (YW+1)'(Y_MAX - TANK_SIZE + 1);

    state_t        state_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW:0]   x_inc, x_dec;
    logic [YW:0]   y_inc, y_dec;
    logic [1:0]    dir_q, last_dir_q, btn_icon, mv_dir;
    logic [HW-1:0] hold_q;
    logic [FW-1:0] cool_q;
    logic          ack_q, moving_q, fire_q, fire_prev_q;
    logic          tick, dir_ok, fire_edge, moved;

    // neg flags a subtraction that went below zero in the extra top bit.
    function automatic logic [XW-1:0] clamp_x(input logic [XW:0] v, input logic neg);
        return (neg || v < X_LO) ? X_LO[XW-1:0] : (v > X_HI) ? X_HI[XW-1:0] : v[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [YW:0] v, input logic neg);
        return (neg || v < Y_LO) ? Y_LO[YW-1:0] : (v > Y_HI) ? Y_HI[YW-1:0] : v[YW-1:0];
    endfunction

    tick_gen #(.TICK_CNT(TICK_CNT)) u_tick (
        .clk25   (clk25),
        .reset_n (reset_n),
        .tick    (tick)
    );

    always_comb begin
        dir_ok    = onehot_dir_valid(player[3:0]);
        btn_icon  = btn_to_icon(player[3:0]);
        fire_edge = |(player & BTN_FIRE) && !fire_prev_q;
        // Bounce retreats opposite to the last move: flipping bit0 swaps UP/DOWN and LEFT/RIGHT.
        mv_dir    = (state_q == BOUNCE) ? {last_dir_q[1], ~last_dir_q[0]} : btn_icon;
        x_inc     = {1'b0, x_q} + (XW+1)'(STEP);
        x_dec     = {1'b0, x_q} - (XW+1)'(STEP);
        y_inc     = {1'b0, y_q} + (YW+1)'(STEP);
        y_dec     = {1'b0, y_q} - (YW+1)'(STEP);
        x_d       = (mv_dir == ICON_RIGHT) ? clamp_x(x_inc, 1'b0) :
                    (mv_dir == ICON_LEFT)  ? clamp_x(x_dec, x_dec[XW]) : x_q;
        y_d       = (mv_dir == ICON_DOWN)  ? clamp_y(y_inc, 1'b0) :
                    (mv_dir == ICON_UP)    ? clamp_y(y_dec, y_dec[YW]) : y_q;
        moved     = (x_d != x_q) || (y_d != y_q);
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            state_q     <= RUN;
            x_q         <= spawn_x;
            y_q         <= spawn_y;
            dir_q       <= ICON_UP;
            last_dir_q  <= ICON_UP;
            ack_q       <= 1'b0;
            moving_q    <= 1'b0;
            fire_q      <= 1'b0;
            fire_prev_q <= 1'b0;
            hold_q      <= '0;
            cool_q      <= '0;
        end else begin
            fire_prev_q <= player[4];
            moving_q    <= 1'b0;
            fire_q      <= 1'b0;
            if (tick && hold_q != '0) hold_q <= hold_q - HW'(1);
            if (tick && cool_q != '0) cool_q <= cool_q - FW'(1);
            if (explosion_flag) begin
                state_q <= RESPAWN;
                x_q     <= spawn_x;
                y_q     <= spawn_y;
                dir_q   <= ICON_UP;
                ack_q   <= 1'b1;
                cool_q  <= '0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (dir_ok) dir_q <= btn_icon;
                        if (tick && dir_ok && hold_q == '0) begin
                            x_q        <= x_d;
                            y_q        <= y_d;
                            last_dir_q <= btn_icon;
                            moving_q   <= moved;
                        end
                        if (fire_edge && cool_q == '0 && hold_q == '0) begin
                            fire_q <= 1'b1;
                            cool_q <= FW'(FIRE_COOLDOWN);
                        end
                        if (wall_hit) state_q <= BOUNCE;
                    end
                    BOUNCE: begin
                        if (tick) begin
                            x_q      <= x_d;
                            y_q      <= y_d;
                            moving_q <= moved;
                            state_q  <= RUN;
                        end
                    end
                    default: begin
                        ack_q   <= 1'b0;
                        hold_q  <= HW'(RESPAWN_HOLD);
                        state_q <= RUN;
                    end
                endcase
            end
        end
    end

    assign red_explosion_ack = ack_q;
    assign x_tank            = x_q;
    assign y_tank            = y_q;
    assign direction         = dir_q;
    assign moving            = moving_q;
    assign fire              = fire_q;
endmodule

// File: tb/tb_tank_motion_ctrl.sv
// tb_tank_motion_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_tank_motion_ctrl;
    localparam int TICK  = 3;
    localparam int HOLD  = 4;
    localparam int COOL  = 2;
    localparam int STEP  = 1;
    localparam int XLO   = 0;
    localparam int XHI   = 639 - 32 + 1;
    localparam int YLO   = 0;
    localparam int YHI   = 479 - 32 + 1;

    logic       clk25 = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] spawn_x = '0;
    logic [8:0] spawn_y = '0;
    logic [4:0] player = '0;
    logic       wall_hit = 1'b0;
    logic       explosion_flag = 1'b0;
    logic       red_explosion_ack, moving, fire;
    logic [9:0] x_tank;
    logic [8:0] y_tank;
    logic [1:0] direction;

    int checks = 0;
    int failures = 0;

    tank_motion_ctrl #(
        .TICK_CNT(TICK), .STEP(STEP), .RESPAWN_HOLD(HOLD), .FIRE_COOLDOWN(COOL)
    ) dut (
        .clk25(clk25), .reset_n(reset_n), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .player(player), .wall_hit(wall_hit), .explosion_flag(explosion_flag),
        .red_explosion_ack(red_explosion_ack), .x_tank(x_tank), .y_tank(y_tank),
        .direction(direction), .moving(moving), .fire(fire)
    );

    always #20 clk25 = ~clk25;

    initial begin
        #2ms;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Behavioural model: facing 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT; mode 0 normal, 1 recoil, 2 exploded.
    int dx_tab[4] = '{0, 0, -1, 1};
    int dy_tab[4] = '{-1, 1, 0, 0};
    int m_x, m_y, m_dir, m_last, m_mode, m_cnt, m_cool, m_hold;
    bit m_ack, m_mov, m_fire, m_prev, m_tk;

    function automatic int clampv(input int v, input int lo, input int hi);
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction

    function automatic int icon_of(input logic [3:0] d);
        case (d)
            4'b0001: return 1;
            4'b0010: return 3;
            4'b0100: return 0;
            default: return 2;
        endcase
    endfunction

    task automatic model_move(input int d);
        int nx = m_x + dx_tab[d] * STEP;
        int ny = m_y + dy_tab[d] * STEP;
        if (dx_tab[d] != 0) nx = clampv(nx, XLO, XHI);
        if (dy_tab[d] != 0) ny = clampv(ny, YLO, YHI);
        m_mov = (nx != m_x) || (ny != m_y);
        m_x = nx;
        m_y = ny;
    endtask

    task automatic model_step();
        bit pressed, valid;
        int old_hold, old_cool;
        if (!reset_n) begin
            m_x = spawn_x; m_y = spawn_y; m_dir = 0; m_last = 0; m_mode = 0;
            m_ack = 0; m_mov = 0; m_fire = 0; m_prev = 0; m_tk = 0;
            m_cnt = 0; m_cool = 0; m_hold = 0;
            return;
        end
        m_tk = (m_cnt == TICK);
        m_cnt = m_tk ? 0 : m_cnt + 1;
        m_mov = 0;
        m_fire = 0;
        pressed = player[4] && !m_prev;
        m_prev = player[4];
        old_hold = m_hold;
        old_cool = m_cool;
        if (m_tk && m_hold > 0) m_hold--;
        if (m_tk && m_cool > 0) m_cool--;
        valid = $countones(player[3:0]) == 1;
        if (explosion_flag) begin
            m_mode = 2; m_x = spawn_x; m_y = spawn_y; m_dir = 0; m_ack = 1; m_cool = 0;
        end else if (m_mode == 2) begin
            m_ack = 0; m_hold = HOLD; m_mode = 0;
        end else if (m_mode == 0) begin
            if (valid) m_dir = icon_of(player[3:0]);
            if (m_tk && valid && old_hold == 0) begin
                m_last = m_dir;
                model_move(m_dir);
            end
            if (pressed && old_cool == 0 && old_hold == 0) begin
                m_fire = 1;
                m_cool = COOL;
            end
            if (wall_hit) m_mode = 1;
        end else if (m_tk) begin
            model_move(m_last ^ 1);
            m_mode = 0;
        end
    endtask

    function automatic logic [23:0] obs();
        return {x_tank, y_tank, direction, red_explosion_ack, moving, fire};
    endfunction

    function automatic logic [23:0] expv();
        return {10'(m_x), 9'(m_y), 2'(m_dir), m_ack, m_mov, m_fire};
    endfunction

    task automatic cyc();
        @(posedge clk25);
        model_step();
        @(negedge clk25);
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 4 * (TICK + 1); i++) begin
            cyc();
            if (m_tk) return;
        end
        failures++;
        $display("FAIL wait_tick no tick within bound");
    endtask

    task automatic do_reset(input int sx, input int sy);
        spawn_x = 10'(sx); spawn_y = 9'(sy);
        player = '0; wall_hit = 0; explosion_flag = 0; reset_n = 0;
        cyc();
        cyc();
        reset_n = 1;
    endtask

    task automatic test_reset();
        do_reset(100, 200);
        checks++; if (x_tank !== 10'd100) begin failures++; $display("FAIL reset_x got=%0d exp=100", x_tank); end
        checks++; if (y_tank !== 9'd200) begin failures++; $display("FAIL reset_y got=%0d exp=200", y_tank); end
        checks++; if (direction !== 2'b00) begin failures++; $display("FAIL reset_dir got=%b exp=00", direction); end
        checks++; if ({red_explosion_ack, moving, fire} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {red_explosion_ack, moving, fire}); end
    endtask

    task automatic test_move_clamp();
        do_reset(606, 300);
        player = 5'b00010;
        wait_tick();
        checks++; if (x_tank !== 10'd607) begin failures++; $display("FAIL move_x1 got=%0d exp=607", x_tank); end
        checks++; if (moving !== 1'b1) begin failures++; $display("FAIL move_moving1 got=%b exp=1", moving); end
        checks++; if (direction !== 2'b11) begin failures++; $display("FAIL move_dir got=%b exp=11", direction); end
        cyc();
        checks++; if (moving !== 1'b0) begin failures++; $display("FAIL move_moving_drop got=%b exp=0", moving); end
        wait_tick();
        checks++; if (x_tank !== 10'd608) begin failures++; $display("FAIL move_x2 got=%0d exp=608", x_tank); end
        wait_tick();
        checks++; if (x_tank !== 10'd608 || moving !== 1'b0) begin failures++; $display("FAIL move_clamp got=%0d/%b exp=608/0", x_tank, moving); end
        checks++; if (y_tank !== 9'd300) begin failures++; $display("FAIL move_y got=%0d exp=300", y_tank); end
    endtask

    task automatic test_invalid_input();
        player = 5'b00101;
        for (int t = 0; t < 10; t++) wait_tick();
        checks++; if ({x_tank, y_tank, direction} !== {10'd608, 9'd300, 2'b11}) begin failures++; $display("FAIL invalid_hold got=%0d,%0d,%b exp=608,300,11", x_tank, y_tank, direction); end
    endtask

    task automatic test_wall_bounce();
        do_reset(300, 50);
        player = 5'b00100;
        wait_tick();
        checks++; if (y_tank !== 9'd49) begin failures++; $display("FAIL bounce_y1 got=%0d exp=49", y_tank); end
        wall_hit = 1;
        cyc();
        wall_hit = 0;
        player = 5'b01000;
        wait_tick();
        checks++; if ({x_tank, y_tank} !== {10'd300, 9'd50}) begin failures++; $display("FAIL bounce_pos got=%0d,%0d exp=300,50", x_tank, y_tank); end
        checks++; if (direction !== 2'b00 || moving !== 1'b1) begin failures++; $display("FAIL bounce_dir_mv got=%b/%b exp=00/1", direction, moving); end
    endtask

    task automatic test_explosion();
        do_reset(300, 300);
        player = 5'b00010;
        wait_tick();
        checks++; if (x_tank !== 10'd301) begin failures++; $display("FAIL expl_premove got=%0d exp=301", x_tank); end
        spawn_x = 10'd40; spawn_y = 9'd60;
        explosion_flag = 1;
        cyc();
        checks++; if ({x_tank, y_tank, direction, red_explosion_ack} !== {10'd40, 9'd60, 2'b00, 1'b1}) begin failures++; $display("FAIL expl_enter got=%0d,%0d,%b,%b exp=40,60,00,1", x_tank, y_tank, direction, red_explosion_ack); end
        cyc();
        cyc();
        checks++; if (red_explosion_ack !== 1'b1) begin failures++; $display("FAIL expl_ack_hold got=%b exp=1", red_explosion_ack); end
        explosion_flag = 0;
        cyc();
        checks++; if (red_explosion_ack !== 1'b0) begin failures++; $display("FAIL expl_ack_drop got=%b exp=0", red_explosion_ack); end
        for (int t = 1; t <= HOLD; t++) begin
            wait_tick();
            checks++; if (x_tank !== 10'd40) begin failures++; $display("FAIL expl_hold%0d got=%0d exp=40", t, x_tank); end
        end
        wait_tick();
        checks++; if (x_tank !== 10'd41 || moving !== 1'b1) begin failures++; $display("FAIL expl_release got=%0d/%b exp=41/1", x_tank, moving); end
    endtask

    task automatic test_fire_cooldown();
        int pulses = 0;
        do_reset(200, 200);
        wait_tick();
        player = 5'b10000; cyc(); pulses += int'(fire);
        checks++; if (fire !== 1'b1) begin failures++; $display("FAIL fire_first got=%b exp=1", fire); end
        player = 5'b00000; cyc(); pulses += int'(fire);
        player = 5'b10000; cyc(); pulses += int'(fire);
        player = 5'b00000; cyc(); pulses += int'(fire);
        checks++; if (pulses != 1) begin failures++; $display("FAIL fire_dropped got=%0d pulses exp=1", pulses); end
        wait_tick();
        wait_tick();
        player = 5'b10000; cyc();
        checks++; if (fire !== 1'b1) begin failures++; $display("FAIL fire_second got=%b exp=1", fire); end
        cyc();
        checks++; if (fire !== 1'b0) begin failures++; $display("FAIL fire_one_cycle got=%b exp=0", fire); end
    endtask

    task automatic test_reset_override();
        explosion_flag = 1;
        cyc();
        checks++; if (red_explosion_ack !== 1'b1) begin failures++; $display("FAIL ovr_ack_set got=%b exp=1", red_explosion_ack); end
        spawn_x = 10'd123; spawn_y = 9'd45; reset_n = 0;
        cyc();
        checks++; if ({red_explosion_ack, x_tank, y_tank, direction} !== {1'b0, 10'd123, 9'd45, 2'b00}) begin failures++; $display("FAIL ovr_reset got=%b,%0d,%0d,%b exp=0,123,45,00", red_explosion_ack, x_tank, y_tank, direction); end
        explosion_flag = 0; reset_n = 1;
        cyc();
        checks++; if (red_explosion_ack !== 1'b0) begin failures++; $display("FAIL ovr_after got=%b exp=0", red_explosion_ack); end
    endtask

    task automatic test_random();
        int expl_left = 0;
        do_reset($urandom_range(XLO, XHI), $urandom_range(YLO, YHI));
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) player = {1'($urandom_range(0, 1)), 4'(1 << $urandom_range(0, 3))};
            else if (r == 6) player = '0;
            else if (r == 7) player = 5'($urandom);
            wall_hit = ($urandom_range(0, 29) == 0);
            if (expl_left > 0) expl_left--;
            else if ($urandom_range(0, 149) == 0) expl_left = $urandom_range(1, 6);
            explosion_flag = (expl_left > 0);
            reset_n = ($urandom_range(0, 399) != 0);
            spawn_x = 10'($urandom_range(XLO, XHI));
            spawn_y = 9'($urandom_range(YLO, YHI));
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d got={x%0d y%0d d%b a%b m%b f%b} exp={x%0d y%0d d%0d a%0d m%0d f%0d}",
                         i, x_tank, y_tank, direction, red_explosion_ack, moving, fire,
                         m_x, m_y, m_dir, m_ack, m_mov, m_fire);
            end
        end
        reset_n = 1; explosion_flag = 0; wall_hit = 0;
    endtask

    initial begin
        @(negedge clk25);
        test_reset();
        test_move_clamp();
        test_invalid_input();
        test_wall_bounce();
        test_explosion();
        test_fire_cooldown();
        test_reset_override();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
